// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main control FSM. Steps each instruction through
// fetch/decode/execute/memory/write-back states and drives the datapath
// strobes. Also provides an illegal-opcode trap and a retired-instruction counter.
module multicycle_control_fsm #(
    parameter int unsigned USE_MEM_READY = 1,
    parameter int unsigned ENABLE_JUMPS  = 1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_retired
);

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAddr  = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StExecute  = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10,
        StJalr     = 4'd11,
        StUpper    = 4'd12,
        StTrap     = 4'd15
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    // Latched instruction class: distinguishes load/store and LUI/AUIPC.
    localparam logic [1:0] ClsLoad  = 2'd0;
    localparam logic [1:0] ClsStore = 2'd1;
    localparam logic [1:0] ClsLui   = 2'd2;
    localparam logic [1:0] ClsAuipc = 2'd3;

    state_e           state_q, state_d;
    logic [1:0]       cls_q, cls_d;
    logic             imm_q, imm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready;
    logic             jumps_ok;
    logic             retire;

    assign ready    = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
    assign jumps_ok = (ENABLE_JUMPS != 0);

    // State, latched opcode class and retired counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cls_q   <= ClsLoad;
            imm_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            imm_q   <= imm_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, class latch and retire-count logic.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        imm_d   = imm_q;
        retire  = 1'b0;
        case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: if (ready) state_d = StDecode;
            StDecode: begin
                imm_d = (opcode == OpImm);
                case (opcode)
                    OpStore: cls_d = ClsStore;
                    OpLui:   cls_d = ClsLui;
                    OpAuipc: cls_d = ClsAuipc;
                    default: cls_d = ClsLoad;
                endcase
                case (opcode)
                    OpLoad, OpStore: state_d = StMemAddr;
                    OpReg, OpImm:    state_d = StExecute;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = jumps_ok ? StJal : StTrap;
                    OpJalr:          state_d = jumps_ok ? StJalr : StTrap;
                    OpLui, OpAuipc:  state_d = jumps_ok ? StUpper : StTrap;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAddr:  state_d = (cls_q == ClsStore) ? StMemWrite : StMemRead;
            StMemRead:  if (ready) state_d = StMemWb;
            StMemWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StMemWrite: begin
                if (ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StExecute: state_d = StAluWb;
            StAluWb, StBranch, StJal, StJalr, StUpper: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StIdle;
        endcase
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Datapath strobes decoded from the current state (FETCH also uses ready).
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'd0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'd0;
        alu_src_b     = 2'd0;
        alu_op        = 2'b00;
        illegal       = 1'b0;
        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = ready;
                pc_write  = ready;
            end
            StDecode: begin
                // ALUOut <= old PC + imm, used later by branch/JAL targets.
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
            end
            StMemAddr: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
            end
            StMemRead: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWrite: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            StExecute: begin
                alu_src_a = 2'd1;
                alu_src_b = imm_q ? 2'd2 : 2'd0;
                alu_op    = 2'b10;
            end
            StAluWb: reg_write = 1'b1;
            StBranch: begin
                alu_src_a     = 2'd1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
            end
            StJal: begin
                reg_write = 1'b1;
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                pc_write  = 1'b1;
                pc_source = 2'd1;
            end
            StJalr: begin
                reg_write = 1'b1;
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                pc_write  = 1'b1;
                pc_source = 2'd2;
            end
            StUpper: begin
                alu_src_a = (cls_q == ClsLui) ? 2'd3 : 2'd2;
                alu_src_b = 2'd2;
                reg_write = 1'b1;
            end
            StTrap:  illegal = 1'b1;
            default: ;
        endcase
    end

    assign state         = state_q;
    assign instr_retired = cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: random instruction streams with
// random memory wait states, compared each cycle against a per-instruction
// state-sequence model; plus reset, trap, jumps-disabled and mid-store reset cases.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        mem_ready;

    logic        pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
    logic        mem_to_reg, reg_write, illegal;
    logic [1:0]  pc_source, alu_src_a, alu_src_b, alu_op;
    logic [3:0]  state;
    logic [31:0] instr_retired;

    logic        nj_pc_write, nj_pc_write_cond, nj_ir_write, nj_iord, nj_mem_read;
    logic        nj_mem_write, nj_mem_to_reg, nj_reg_write, nj_illegal;
    logic [1:0]  nj_pc_source, nj_alu_src_a, nj_alu_src_b, nj_alu_op;
    logic [3:0]  nj_state;
    logic [31:0] nj_instr_retired;

    logic [16:0] outs;
    assign outs = {pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read, mem_write,
                   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal};

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal), .state(state),
        .instr_retired(instr_retired)
    );

    multicycle_control_fsm #(.USE_MEM_READY(1), .ENABLE_JUMPS(0), .CNT_W(32)) dut_nj (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(nj_pc_write), .pc_write_cond(nj_pc_write_cond), .pc_source(nj_pc_source),
        .ir_write(nj_ir_write), .iord(nj_iord), .mem_read(nj_mem_read),
        .mem_write(nj_mem_write), .mem_to_reg(nj_mem_to_reg), .reg_write(nj_reg_write),
        .alu_src_a(nj_alu_src_a), .alu_src_b(nj_alu_src_b), .alu_op(nj_alu_op),
        .illegal(nj_illegal), .state(nj_state), .instr_retired(nj_instr_retired)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Number of steps an instruction takes (ignoring wait repeats).
    function automatic int n_steps(input logic [6:0] op);
        case (op)
            OP_LOAD:                 return 5;
            OP_STORE, OP_REG, OP_IMM: return 4;
            default:                 return 3;
        endcase
    endfunction

    // Step i of an instruction, named by the documented state number.
    function automatic int step_at(input logic [6:0] op, input int i);
        if (i == 0) return 1;
        if (i == 1) return 2;
        case (op)
            OP_LOAD:        return (i == 2) ? 3 : (i == 3) ? 4 : 5;
            OP_STORE:       return (i == 2) ? 3 : 6;
            OP_REG, OP_IMM: return (i == 2) ? 7 : 8;
            OP_BR:          return 9;
            OP_JAL:         return 10;
            OP_JALR:        return 11;
            default:        return 12;
        endcase
    endfunction

    // Expected output vector for a step, from the documented per-state strobes.
    function automatic logic [16:0] exp_out(input int st, input logic rdy, input logic [6:0] op);
        logic pw, pwc, irw, io, mr, mw, m2r, rw, ill;
        logic [1:0] ps, a, b, aop;
        {pw, pwc, irw, io, mr, mw, m2r, rw, ill} = '0;
        {ps, a, b, aop} = '0;
        case (st)
            1:  begin mr = 1; b = 1; irw = rdy; pw = rdy; end
            2:  begin a = 2; b = 2; end
            3:  begin a = 1; b = 2; end
            4:  begin mr = 1; io = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mw = 1; io = 1; end
            7:  begin a = 1; b = (op == OP_IMM) ? 2'd2 : 2'd0; aop = 2'b10; end
            8:  rw = 1;
            9:  begin a = 1; aop = 2'b01; pwc = 1; ps = 1; end
            10: begin rw = 1; a = 2; b = 1; pw = 1; ps = 1; end
            11: begin rw = 1; a = 2; b = 1; pw = 1; ps = 2; end
            12: begin a = (op == OP_LUI) ? 2'd3 : 2'd2; b = 2; rw = 1; end
            15: ill = 1;
            default: ;
        endcase
        return {pw, pwc, ps, irw, io, mr, mw, m2r, rw, a, b, aop, ill};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset both DUTs, check idle outputs, release and leave them in FETCH.
    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        opcode = '0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_state", 32'(state), 0);
        check_val("rst_outs", 32'(outs), 0);
        check_val("rst_count", instr_retired, 0);
        exp_cnt = 0;
        rst_n = 1'b1;
        #1;
        check_val("rel_idle", 32'(state), 0);
        next_cycle();
    endtask

    // Run one instruction starting in FETCH. forced < 0: random waits everywhere;
    // forced >= 0: FETCH ready at once, MEM_READ/MEM_WRITE wait exactly 'forced' cycles.
    task automatic run_instr(input logic [6:0] op, input int forced,
                             output int st4_cycles, output int pwc_cycles);
        st4_cycles = 0;
        pwc_cycles = 0;
        for (int i = 0; i < n_steps(op); i++) begin
            int  st;
            int  waits;
            bit  done;
            bit  waitable;
            logic rdy;
            st = step_at(op, i);
            waits = 0;
            done = 1'b0;
            waitable = (st == 1) || (st == 4) || (st == 6);
            while (!done) begin
                // Opcode is garbage after DECODE: the FSM must use its latched copy.
                opcode = (i >= 2) ? 7'($urandom) : op;
                if (!waitable) rdy = 1'($urandom);
                else if (forced >= 0) rdy = (st == 1) ? 1'b1 : (waits >= forced);
                else rdy = ($urandom_range(0, 3) != 0) || (waits >= 6);
                mem_ready = rdy;
                #1;
                check_val("state", 32'(state), 32'(st));
                check_val("outs", 32'(outs), 32'(exp_out(st, rdy, op)));
                if (state == 4'd4) st4_cycles++;
                if (pc_write_cond) pwc_cycles++;
                done = !waitable || rdy;
                waits++;
                next_cycle();
            end
        end
        exp_cnt++;
        check_val("retired", instr_retired, 32'(exp_cnt));
    endtask

    logic [6:0] legal_ops [9];
    int s4, pwc;

    initial begin
        legal_ops = '{OP_LOAD, OP_STORE, OP_REG, OP_IMM, OP_BR, OP_JAL, OP_JALR,
                      OP_LUI, OP_AUIPC};
        rst_n = 1'b1;
        mem_ready = 1'b0;
        opcode = '0;
        #2;
        do_reset();

        // Directed: R-type, load with two wait cycles, branch.
        run_instr(OP_REG, 0, s4, pwc);
        run_instr(OP_LOAD, 2, s4, pwc);
        check_val("load_mr_hold", 32'(s4), 3);
        run_instr(OP_BR, 0, s4, pwc);
        check_val("branch_pwc", 32'(pwc), 1);

        // Random instruction stream with random wait states.
        for (int n = 0; n < 120; n++) begin
            run_instr(legal_ops[$urandom_range(0, 8)], -1, s4, pwc);
        end

        // Reset asserted mid MEM_WRITE: strobes drop without a clock edge.
        begin
            int st_seq [4];
            st_seq = '{1, 2, 3, 6};
            for (int i = 0; i < 4; i++) begin
                opcode = (i >= 2) ? 7'($urandom) : OP_STORE;
                mem_ready = (i == 0);
                #1;
                check_val("st_state", 32'(state), 32'(st_seq[i]));
                if (i < 3) next_cycle();
            end
            check_val("st_mw_high", 32'(mem_write), 1);
            check_val("st_count_pre", instr_retired, 32'(exp_cnt));
            #2;
            rst_n = 1'b0;
            #1;
            check_val("st_mw_drop", 32'(mem_write), 0);
            check_val("st_rst_state", 32'(state), 0);
            check_val("st_rst_count", instr_retired, 0);
        end

        // Jumps disabled: JAL traps in the second instance only.
        do_reset();
        mem_ready = 1'b1;
        opcode = OP_JAL;
        #1;
        check_val("nj_fetch", 32'(nj_state), 1);
        next_cycle();
        #1;
        check_val("nj_decode", 32'(nj_state), 2);
        next_cycle();
        opcode = 7'($urandom);
        #1;
        check_val("jal_state", 32'(state), 10);
        check_val("nj_trap_state", 32'(nj_state), 15);
        check_val("nj_illegal", 32'(nj_illegal), 1);

        // Illegal opcode: trap is sticky, counter frozen.
        do_reset();
        run_instr(OP_AUIPC, -1, s4, pwc);
        mem_ready = 1'b1;
        opcode = OP_BAD;
        #1;
        check_val("bad_fetch", 32'(state), 1);
        next_cycle();
        #1;
        check_val("bad_decode", 32'(state), 2);
        next_cycle();
        for (int c = 0; c < 20; c++) begin
            opcode = 7'($urandom);
            mem_ready = 1'($urandom);
            #1;
            check_val("trap_state", 32'(state), 15);
            check_val("trap_outs", 32'(outs), 32'(exp_out(15, mem_ready, OP_BAD)));
            check_val("trap_count", instr_retired, 32'(exp_cnt));
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
